fft_bar_conditioner: RTL and testbench

Upstream feeder of the 4-bar VGA display stage. It accepts one FFT frame of magnitude bins over a valid/ready stream and sums the bins into 4 equal bands. Each band sum is scaled and clamped to a 0..480 bar height, then smoothed with instant-attack / linear-decay. The result is published on `data[3:0]` only at the start of vertical blanking, so the display never tears mid-frame.

---
 rtl/dav_pkg.sv | 16 +
 rtl/bar_smoother.sv | 35 +++
 rtl/fft_bar_conditioner.sv | 134 +++++++++++++
 tb/tb_fft_bar_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dav_pkg.sv
// Shared types and constants for the 4-bar VGA display path.
package dav_pkg;

    localparam int unsigned NBARS = 4;

    typedef logic [9:0] bar_h_t;

    localparam bar_h_t BAR_H_MAX = 10'd480;

    typedef enum logic [1:0] {
        ACCUM,
        HOLD,
        UPDATE
    } cond_state_t;

endpackage

// File: rtl/bar_smoother.sv
// Next bar height from the current height and a band sum: scale, clamp,
// instant attack, linear decay saturating at zero.
module bar_smoother
    import dav_pkg::*;
#(
    parameter int unsigned SUM_W = 20,
    parameter int unsigned SHIFT = 10,
    parameter int unsigned DECAY = 8
) (
    input  bar_h_t           h_cur,
    input  logic [SUM_W-1:0] sum,
    output bar_h_t           h_new
);

    // Zero-extended so the clamp compare stays valid for any SUM_W.
    localparam int unsigned EXT_W = SUM_W + 10;

    logic [EXT_W-1:0] scaled;
    bar_h_t           target;
    bar_h_t           dec_step;
    bar_h_t           decayed;

    always_comb begin
        scaled   = {10'd0, sum} >> SHIFT;
        target   = (scaled > EXT_W'(BAR_H_MAX)) ? BAR_H_MAX : scaled[9:0];
        dec_step = bar_h_t'(DECAY);
        decayed  = (h_cur > dec_step) ? (h_cur - dec_step) : '0;
        if (target >= h_cur) begin
            h_new = target;
        end else begin
            h_new = (decayed > target) ? decayed : target;
        end
    end

endmodule

// File: rtl/fft_bar_conditioner.sv
// Sums an FFT frame into 4 bands, smooths the bar heights and publishes them
// on the rising edge of vertical blanking.
module fft_bar_conditioner
    import dav_pkg::*;
#(
    parameter int unsigned NBINS = 64,
    parameter int unsigned MAG_W = 16,
    parameter int unsigned SHIFT = 10,
    parameter int unsigned DECAY = 8
) (
    input  logic                     vgaclk,
    input  logic                     rst,
    input  logic                     mag_valid,
    output logic                     mag_ready,
    input  logic [MAG_W-1:0]         mag_data,
    input  logic                     mag_last,
    input  logic                     done,
    output bar_h_t [NBARS-1:0]       data,
    output logic                     frame_update,
    output logic                     frame_err
);

    localparam int unsigned IDX_W  = $clog2(NBINS);
    localparam int unsigned BAND_W = $clog2(NBINS / 4);
    localparam int unsigned SUM_W  = MAG_W + BAND_W;

    cond_state_t      state;
    cond_state_t      state_nx;
    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] band_sum [NBARS];
    logic [1:0]       upd_k;
    logic             done_d;
    logic             xfer;
    logic             frame_bad;
    logic             rise;
    logic [1:0]       band;
    bar_h_t           smooth_out;

    assign band = idx[IDX_W-1 -: 2];

    bar_smoother #(
        .SUM_W (SUM_W),
        .SHIFT (SHIFT),
        .DECAY (DECAY)
    ) u_smoother (
        .h_cur (data[upd_k]),
        .sum   (band_sum[upd_k]),
        .h_new (smooth_out)
    );

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        xfer      = 1'b0;
        frame_bad = 1'b0;
        rise      = done && !done_d;
        case (state)
            ACCUM: begin
                xfer = mag_valid && mag_ready;
                if (xfer) begin
                    if (mag_last && (idx == IDX_W'(NBINS - 1))) begin
                        state_nx = HOLD;
                    end else if (mag_last || (idx == IDX_W'(NBINS - 1))) begin
                        frame_bad = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rise) begin
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                if (upd_k == 2'd3) begin
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            idx          <= '0;
            upd_k        <= '0;
            done_d       <= 1'b0;
            mag_ready    <= 1'b0;
            frame_update <= 1'b0;
            frame_err    <= 1'b0;
            data         <= '0;
            for (int unsigned b = 0; b < NBARS; b++) begin
                band_sum[b] <= '0;
            end
        end else begin
            done_d       <= done;
            frame_update <= 1'b0;
            frame_err    <= frame_bad;
            // Ready stays low for one cycle after UPDATE so it trails frame_update.
            mag_ready    <= (state == ACCUM) && (state_nx == ACCUM);

            if (xfer) begin
                if (frame_bad) begin
                    idx <= '0;
                    for (int unsigned b = 0; b < NBARS; b++) begin
                        band_sum[b] <= '0;
                    end
                end else begin
                    idx            <= idx + 1'b1;
                    band_sum[band] <= band_sum[band] + SUM_W'(mag_data);
                end
            end

            if (state == UPDATE) begin
                data[upd_k] <= smooth_out;
                upd_k       <= upd_k + 1'b1;
                if (upd_k == 2'd3) begin
                    frame_update <= 1'b1;
                    idx          <= '0;
                    for (int unsigned b = 0; b < NBARS; b++) begin
                        band_sum[b] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bar_conditioner.sv
// Directed bench for fft_bar_conditioner with a scoreboard of published heights.
module tb_fft_bar_conditioner;

    typedef logic [3:0][9:0] bars_t;

    logic        vgaclk = 1'b0;
    logic        rst;
    logic        mag_valid;
    logic        mag_ready;
    logic [15:0] mag_data;
    logic        mag_last;
    logic        done;
    bars_t       data;
    logic        frame_update;
    logic        frame_err;

    int    n_tests = 0;
    int    n_fail  = 0;
    bars_t exp_q[$];
    int    mdl[4];
    int    fsum[4];

    fft_bar_conditioner #(
        .NBINS (64),
        .MAG_W (16),
        .SHIFT (10),
        .DECAY (8)
    ) dut (
        .vgaclk       (vgaclk),
        .rst          (rst),
        .mag_valid    (mag_valid),
        .mag_ready    (mag_ready),
        .mag_data     (mag_data),
        .mag_last     (mag_last),
        .done         (done),
        .data         (data),
        .frame_update (frame_update),
        .frame_err    (frame_err)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    function automatic int bin_val(input int pattern, input int i);
        int band_v[4] = '{2048, 640, 64, 30000};
        case (pattern)
            0: return 1024;
            1: return (i < 16) ? 65535 : 0;
            3: return 30080;
            4: return band_v[i / 16];
            5: return 320;
            default: return 0;
        endcase
    endfunction

    function automatic int next_h(input int sum, input int cur);
        int t;
        int d;
        t = sum / 1024;
        if (t > 480) t = 480;
        if (t >= cur) return t;
        d = cur - 8;
        if (d < 0) d = 0;
        return (d > t) ? d : t;
    endfunction

    task automatic send_frame(input int pattern, input int nbeats, input int last_at);
        for (int k = 0; k < 4; k++) fsum[k] = 0;
        for (int i = 0; i < nbeats; i++) begin
            int w;
            mag_valid = 1'b1;
            mag_data  = 16'(bin_val(pattern, i));
            mag_last  = (i == last_at);
            w = 0;
            while (mag_ready !== 1'b1 && w < 100) begin
                step();
                w++;
            end
            if (w == 100) chk("ready_wait", {63'd0, mag_ready}, 64'd1);
            step();
            fsum[i / 16] += bin_val(pattern, i);
        end
        mag_valid = 1'b0;
        mag_last  = 1'b0;
    endtask

    task automatic publish();
        bars_t e;
        for (int k = 0; k < 4; k++) begin
            mdl[k] = next_h(fsum[k], mdl[k]);
            e[k]   = 10'(mdl[k]);
        end
        exp_q.push_back(e);
        done = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("bar%0d_timing", k), {54'd0, data[k]}, {54'd0, e[k]});
            chk($sformatf("upd_pulse%0d", k), {63'd0, frame_update}, (k == 3) ? 64'd1 : 64'd0);
        end
        step();
        chk("ready_after_update", {63'd0, mag_ready}, 64'd1);
        done = 1'b0;
    endtask

    // Scoreboard side: every publish must match the oldest pending expectation.
    always @(negedge vgaclk) begin
        if (rst === 1'b0 && frame_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_update", 64'(exp_q.size()), 64'd1);
            end else begin
                bars_t e;
                e = exp_q.pop_front();
                chk("scoreboard_bars", {24'd0, data}, {24'd0, e});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mag_valid = 1'b1;
        mag_data  = '0;
        mag_last  = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        step(); step(); step();
        chk("rst_ready", {63'd0, mag_ready}, 64'd0);
        chk("rst_data", {24'd0, data}, 64'd0);
        chk("rst_update", {63'd0, frame_update}, 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", {63'd0, mag_ready}, 64'd1);
        mag_valid = 1'b0;
        step();

        send_frame(1, 64, 63);
        chk("ready_fell", {63'd0, mag_ready}, 64'd0);
        publish();
        chk("clamp_480", {24'd0, data}, {24'd0, 10'd0, 10'd0, 10'd0, 10'd480});
        send_frame(2, 64, 63);
        publish();
        chk("decay_472", {54'd0, data[0]}, 64'd472);
        send_frame(3, 64, 63);
        publish();
        chk("decay_floor_470", {54'd0, data[0]}, 64'd470);
        send_frame(2, 64, 63);
        publish();
        send_frame(0, 64, 63);
        publish();
        send_frame(4, 64, 63);
        publish();

        send_frame(0, 30, -1);
        rst = 1'b1;
        step();
        chk("midrst_data", {24'd0, data}, 64'd0);
        chk("midrst_ready", {63'd0, mag_ready}, 64'd0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) mdl[k] = 0;

        send_frame(0, 21, 20);
        chk("err_early", {63'd0, frame_err}, 64'd1);
        chk("ready_after_err", {63'd0, mag_ready}, 64'd1);
        step();
        chk("err_pulse_end", {63'd0, frame_err}, 64'd0);
        send_frame(0, 64, 63);
        publish();
        chk("clean_after_err", {24'd0, data}, {24'd0, 10'd16, 10'd16, 10'd16, 10'd16});

        send_frame(0, 64, -1);
        chk("err_missing_last", {63'd0, frame_err}, 64'd1);
        chk("ready_missing_last", {63'd0, mag_ready}, 64'd1);
        step();

        send_frame(5, 64, 63);
        publish();
        send_frame(5, 64, 63);
        publish();
        send_frame(2, 64, 63);
        publish();
        chk("decay_sat_zero", {24'd0, data}, 64'd0);

        done = 1'b1;
        step(); step(); step();
        send_frame(0, 64, 63);
        mag_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hold_ready_low", {63'd0, mag_ready}, 64'd0);
        end
        chk("hold_no_publish", {24'd0, data}, 64'd0);
        mag_valid = 1'b0;
        done = 1'b0;
        step();
        publish();

        step(); step(); step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
